// File: rtl/vga_color_pkg.sv
// Shared colour encoding for the VGA pixel colour source.
// Colours are 3-bit {R,G,B} values, one bit per DAC channel.
package vga_color_pkg;

    localparam int RGB_W = 3;

    typedef enum logic [RGB_W-1:0] {
        BLACK   = 3'b000,
        BLUE    = 3'b001,
        GREEN   = 3'b010,
        CYAN    = 3'b011,
        RED     = 3'b100,
        MAGENTA = 3'b101,
        YELLOW  = 3'b110,
        WHITE   = 3'b111
    } colour_t;

    localparam colour_t RESET_COLOUR = BLACK;

    // Steps through all eight colours; WHITE rolls over to BLACK.
    function automatic colour_t next_colour(input colour_t c);
        return colour_t'(c + RGB_W'(1));
    endfunction

endpackage

// File: rtl/vga_color_config_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stability filter and
// rising-edge detector producing a single-cycle press pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    logic             btn_s;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_q <= btn_raw;
            btn_s  <= sync_q;
        end
    end

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            level_q <= 1'b0;
        end else if (btn_s == level_q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            level_q <= btn_s;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level_q;
        end
    end

    assign btn_level = level_q;
    assign btn_press = level_q & ~level_d;

endmodule

// File: rtl/vga_color_config.sv
// Pixel colour source: a debounced button steps a 3-bit colour, which is
// driven onto the pixel bus only during the visible area.
module vga_color_config
    import vga_color_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             nextRgb,
    input  logic             video_on,
    output logic [RGB_W-1:0] rgb
);

    logic    btn_level;
    logic    btn_press;
    colour_t colour;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (nextRgb),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colour <= RESET_COLOUR;
        end else if (btn_press && btn_level) begin
            colour <= next_colour(colour);
        end
    end

    // Blanking is combinational so the pixel stays aligned with the sync generator.
    assign rgb = video_on ? colour : BLACK;

endmodule

// File: tb/tb_vga_color_config.sv
// Directed self-checking bench for vga_color_config with a short debounce window.
module tb_vga_color_config;
    import vga_color_pkg::*;

    localparam int DEB = 4;

    logic             clk;
    logic             rst_n;
    logic             nextRgb;
    logic             video_on;
    logic [RGB_W-1:0] rgb;

    int vectors;
    int miscompares;

    logic [RGB_W-1:0] seq [0:8];

    vga_color_config #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .nextRgb (nextRgb),
        .video_on(video_on),
        .rgb     (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic btn, input logic vid, input int cycles);
        nextRgb  = btn;
        video_on = vid;
        tick(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [RGB_W-1:0] expected);
        vectors++;
        assert (rgb === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: rgb=%b expected=%b", tag, rgb, expected);
        end
    endtask

    // One clean press: no change early, new colour within 2+DEB+2 cycles, no repeat while held.
    task automatic cleanPress(input string tag, input logic [RGB_W-1:0] old_c,
                              input logic [RGB_W-1:0] new_c);
        applyStimulus(1'b1, 1'b1, 5);
        checkOutput({tag, "_early"}, old_c);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput({tag, "_step"}, new_c);
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput({tag, "_held"}, new_c);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput({tag, "_release"}, new_c);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        #1;
        checkOutput("reset_assert", BLACK);
        applyStimulus(1'b0, 1'b1, 2);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        seq[0] = BLUE;  seq[1] = GREEN;   seq[2] = CYAN;   seq[3] = RED;
        seq[4] = MAGENTA; seq[5] = YELLOW; seq[6] = WHITE; seq[7] = BLACK;
        seq[8] = BLUE;

        $display("[TB] reset with button held and video on");
        rst_n    = 1'b0;
        video_on = 1'b1;
        nextRgb  = 1'b1;
        #1;
        checkOutput("reset_immediate", BLACK);
        applyStimulus(1'b1, 1'b1, 6);
        checkOutput("reset_held", BLACK);
        nextRgb = 1'b0;
        tick(1);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("idle_after_reset", BLACK);

        $display("[TB] clean press");
        cleanPress("clean", BLACK, BLUE);

        $display("[TB] bouncing press and short pulse");
        for (int i = 0; i < 6; i++) applyStimulus((i % 2) == 0, 1'b1, 2);
        checkOutput("bounce_no_step", BLUE);
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput("bounce_single_step", GREEN);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("bounce_release", GREEN);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("short_pulse", GREEN);

        $display("[TB] wrap through all colours");
        resetDut();
        for (int i = 0; i < 9; i++) begin
            cleanPress($sformatf("wrap%0d", i), (i == 0) ? BLACK : seq[i-1], seq[i]);
        end

        $display("[TB] blanking");
        for (int i = 1; i < 5; i++) cleanPress($sformatf("to_magenta%0d", i), seq[i-1], seq[i]);
        video_on = 1'b0;
        #1;
        checkOutput("blank_off", BLACK);
        video_on = 1'b1;
        #1;
        checkOutput("blank_on", MAGENTA);
        video_on = 1'b0;
        #1;
        checkOutput("blank_off_again", BLACK);
        applyStimulus(1'b1, 1'b0, 8);
        checkOutput("blank_press_hidden", BLACK);
        applyStimulus(1'b1, 1'b0, 12);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("blank_release_hidden", BLACK);
        video_on = 1'b1;
        #1;
        checkOutput("blank_press_advanced", YELLOW);

        $display("[TB] reset mid-press");
        resetDut();
        for (int i = 0; i < 3; i++) begin
            cleanPress($sformatf("to_cyan%0d", i), (i == 0) ? BLACK : seq[i-1], seq[i]);
        end
        applyStimulus(1'b1, 1'b1, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("midpress_reset", BLACK);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("midpress_reset_held", BLACK);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 5);
        checkOutput("midpress_early", BLACK);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("midpress_step", BLUE);
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput("midpress_held", BLUE);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("midpress_release", BLUE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
